// File: rtl/alu_issue_stage.sv
// Operand fetch / issue stage feeding an 8-bit ALU, with 4x8 regfile and writeback.
// Define ALU_ISSUE_FORWARD_EN for RAW forwarding; otherwise hazards stall one cycle.
module alu_issue_stage #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_instr,
    input  logic              ld_valid,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [1:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [1:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] OP_NOP = 2'd3;

    logic [DATA_W-1:0] rf [4];
    logic              ex_valid;
    logic [1:0]        ex_rd;
    logic [1:0]        ex_op;

    logic [1:0]        dec_op;
    logic [1:0]        dec_rd;
    logic [1:0]        dec_rs1;
    logic [1:0]        dec_rs2;
    logic              wb_en;
    logic              hz1;
    logic              hz2;
    logic              accept;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign dec_op  = in_instr[7:6];
    assign dec_rd  = in_instr[5:4];
    assign dec_rs1 = in_instr[3:2];
    assign dec_rs2 = in_instr[1:0];

    assign wb_en = ex_valid && (ex_op != OP_NOP);
    assign hz1   = wb_en && (dec_rs1 == ex_rd);
    assign hz2   = wb_en && (dec_rs2 == ex_rd);

`ifdef ALU_ISSUE_FORWARD_EN
    assign rd1      = hz1 ? alu_result : rf[dec_rs1];
    assign rd2      = hz2 ? alu_result : rf[dec_rs2];
    assign in_ready = !ld_valid;
`else
    assign rd1      = rf[dec_rs1];
    assign rd2      = rf[dec_rs2];
    assign in_ready = !ld_valid && !(in_valid && (hz1 || hz2));
`endif

    assign accept   = in_valid && in_ready;
    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= RESET_VAL;
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_op         <= '0;
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_operation <= '0;
            wb_valid      <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
        end else begin
            // Writeback is written last so it wins a same-address load.
            if (ld_valid) rf[ld_addr] <= ld_data;
            if (wb_en) rf[ex_rd] <= alu_result;
            ex_valid <= accept;
            if (accept) begin
                alu_operand1  <= rd1;
                alu_operand2  <= rd2;
                alu_operation <= dec_op;
                ex_op         <= dec_op;
                ex_rd         <= dec_rd;
            end
            wb_valid <= wb_en;
            if (wb_en) begin
                wb_addr <= ex_rd;
                wb_data <= alu_result;
            end
        end
    end

endmodule
